// File: rtl/rdata_chan_sndr_pkg.sv
// Shared types and constants for the AXI read-data channel sender.
package rdata_chan_sndr_pkg;

  localparam int unsigned BeatCnt = 4;
  localparam int unsigned IdW     = 4;
  localparam int unsigned LenW    = 2;
  localparam int unsigned LineW   = 128;
  localparam int unsigned WordW   = 32;

  // Encodings are fixed so the state is readable on a waveform as RDAT_S_*.
  typedef enum logic [1:0] {
    RdatSIdle = 2'b00,
    RdatSSend = 2'b01,
    RdatSDefo = 2'b11
  } rdat_state_e;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [LenW-1:0]  len;
    logic [LineW-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/rdata_chan_sndr_if.sv
// R channel plus response-push signals; master is the sender, slave the peer side.
interface rdata_chan_sndr_if;
  import rdata_chan_sndr_pkg::*;

  logic             rvalid;
  logic             rready;
  logic [IdW-1:0]   rid;
  logic [WordW-1:0] rdata;
  logic             rlast;
  logic             rsp_valid;
  logic [IdW-1:0]   rsp_id;
  logic [LenW-1:0]  rsp_len;
  logic [LineW-1:0] rsp_data;
  logic             rsp_full;
  logic             finish_srd;

  modport master (
    output rvalid, rid, rdata, rlast, rsp_full, finish_srd,
    input  rready, rsp_valid, rsp_id, rsp_len, rsp_data
  );

  modport slave (
    input  rvalid, rid, rdata, rlast, rsp_full, finish_srd,
    output rready, rsp_valid, rsp_id, rsp_len, rsp_data
  );

endinterface

// File: rtl/rdat_rsp_fifo.sv
// Register FIFO holding pending read responses; head entry is always visible.
module rdat_rsp_fifo
  import rdata_chan_sndr_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Aw    = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  rsp_entry_t   entry_i,
  input  logic         pop_i,
  output rsp_entry_t   head_o,
  output logic [Aw:0]  count_o,
  output logic         full_o,
  output logic         empty_o
);

  rsp_entry_t    mem_q [Depth];
  logic [Aw-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [Aw:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (Aw + 1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rptr_q];

  always_comb begin
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    // Depth is a power of two, so pointers wrap naturally.
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (do_push) mem_q[wptr_q] <= entry_i;
    end
  end

endmodule

// File: rtl/rdata_chan_sndr.sv
// Sends queued read responses as 1-4 beat AXI R bursts in ascending word order.
module rdata_chan_sndr
  import rdata_chan_sndr_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  parameter int unsigned QAW    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  rdata_chan_sndr_if.master  bus
);

  rdat_state_e   state_q, state_d;
  logic [1:0]    beat_q, beat_d;
  logic          fin_q, fin_d;
  rsp_entry_t    entry_in, head;
  logic [QAW:0]  count;
  logic          full, empty, push, pop, send, last_beat, hs;

  assign entry_in = '{id: bus.rsp_id, len: bus.rsp_len, data: bus.rsp_data};
  assign push     = bus.rsp_valid & ~full;

  rdat_rsp_fifo #(
    .Depth (QDEPTH),
    .Aw    (QAW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .entry_i (entry_in),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    pop       = 1'b0;
    send      = 1'b0;
    hs        = 1'b0;
    last_beat = (beat_q == head.len);
    case (state_q)
      // Looking at the incoming push gives single-cycle push-to-rvalid latency.
      RdatSIdle: if (!empty || push) state_d = RdatSSend;
      RdatSSend: begin
        send = 1'b1;
        if (bus.rready) begin
          hs = 1'b1;
          if (!last_beat) begin
            beat_d = beat_q + 2'd1;
          end else begin
            beat_d = '0;
            pop    = 1'b1;
            if (!(count > (QAW + 1)'(1)) && !push) state_d = RdatSIdle;
          end
        end
      end
      RdatSDefo: state_d = RdatSDefo;
      default:   state_d = RdatSDefo;
    endcase
    fin_d = hs & last_beat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RdatSIdle;
      beat_q  <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      fin_q   <= fin_d;
    end
  end

  // Beat fields are forced to zero outside SEND so idle/reset outputs are quiet.
  assign bus.rvalid     = send;
  assign bus.rid        = send ? head.id : '0;
  assign bus.rdata      = send ? head.data[{beat_q, 5'b0} +: WordW] : '0;
  assign bus.rlast      = send & last_beat;
  assign bus.rsp_full   = full;
  assign bus.finish_srd = fin_q;

endmodule

// File: tb/tb_rdata_chan_sndr.sv
// Scoreboard bench for rdata_chan_sndr: expected beats queued at push, checked on handshake.
module tb_rdata_chan_sndr;
  import rdata_chan_sndr_pkg::*;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rdata_chan_sndr_if bus ();

  rdata_chan_sndr #(
    .QDEPTH (2),
    .QAW    (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t sb[$];
  beat_t exp_b, held;
  logic  held_v = 1'b0;
  logic  prev_last_hs = 1'b0;
  int    n_checks = 0, n_errors = 0;
  int    model_cnt = 0, hs_cnt = 0, fin_cnt = 0;
  int    hs0, fin0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; the push is sampled at the next edge.
  task automatic push_rsp(input logic [3:0] id, input logic [1:0] len, input logic [127:0] data);
    logic  acc;
    beat_t b;
    acc = (model_cnt < 2);
    check_eq("rsp_full", bus.rsp_full, !acc);
    bus.rsp_valid = 1'b1;
    bus.rsp_id    = id;
    bus.rsp_len   = len;
    bus.rsp_data  = data;
    if (acc) begin
      model_cnt++;
      for (int k = 0; k <= int'(len); k++) begin
        b.id   = id;
        b.data = data[32*k +: 32];
        b.last = (k == int'(len));
        sb.push_back(b);
      end
    end
    step();
    bus.rsp_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) step();
    check_eq("drain", sb.size(), 0);
    step();
    step();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v       = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      check_eq("finish_srd", bus.finish_srd, prev_last_hs);
      if (bus.finish_srd) fin_cnt++;
      if (held_v) begin
        check_eq("hold_valid", bus.rvalid, 1);
        check_eq("hold_beat", {bus.rid, bus.rdata, bus.rlast}, held);
      end
      held_v       = bus.rvalid & ~bus.rready;
      held         = {bus.rid, bus.rdata, bus.rlast};
      prev_last_hs = bus.rvalid & bus.rready & bus.rlast;
      if (bus.rvalid && bus.rready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          check_eq("unexpected_beat", 1, 0);
        end else begin
          exp_b = sb.pop_front();
          check_eq("beat", {bus.rid, bus.rdata, bus.rlast}, exp_b);
        end
        if (bus.rlast) model_cnt--;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.rready    = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_id    = '0;
    bus.rsp_len   = '0;
    bus.rsp_data  = '0;
    #12;
    check_eq("rst_rvalid", bus.rvalid, 0);
    check_eq("rst_rlast", bus.rlast, 0);
    check_eq("rst_rid", bus.rid, 0);
    check_eq("rst_rdata", bus.rdata, 0);
    check_eq("rst_full", bus.rsp_full, 0);
    check_eq("rst_finish", bus.finish_srd, 0);
    rst_n = 1'b1;
    step();

    // Single 4-beat burst, rready held high.
    bus.rready = 1'b1;
    hs0 = hs_cnt; fin0 = fin_cnt;
    push_rsp(4'd3, 2'd3, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    check_eq("latency_rvalid", bus.rvalid, 1);
    wait_drain();
    check_eq("t1_hs", hs_cnt - hs0, 4);
    check_eq("t1_fin", fin_cnt - fin0, 1);
    check_eq("t1_idle", bus.rvalid, 0);

    // Backpressure: rready pattern 1,0,0,1 repeating.
    bus.rready = 1'b0;
    hs0 = hs_cnt; fin0 = fin_cnt;
    push_rsp(4'd3, 2'd3, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
    for (int i = 0; i < 16; i++) begin
      bus.rready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    bus.rready = 1'b1;
    wait_drain();
    check_eq("t2_hs", hs_cnt - hs0, 4);
    check_eq("t2_fin", fin_cnt - fin0, 1);

    // Single-beat burst returns straight to idle.
    push_rsp(4'd5, 2'd0, {96'h0, 32'hDEAD_BEEF});
    check_eq("short_rvalid", bus.rvalid, 1);
    check_eq("short_rlast", bus.rlast, 1);
    step();
    check_eq("short_idle", bus.rvalid, 0);
    wait_drain();

    // Back-to-back bursts without a bubble.
    hs0 = hs_cnt; fin0 = fin_cnt;
    push_rsp(4'd1, 2'd1, 128'h0_0000_0000_0000_0000_A1A1_0002_A0A0_0001);
    check_eq("b2b_first", bus.rvalid, 1);
    push_rsp(4'd2, 2'd2, 128'h0000_0000_B2B2_0003_B1B1_0002_B0B0_0001);
    for (int i = 0; i < 4; i++) begin
      check_eq("b2b_rvalid", bus.rvalid, 1);
      step();
    end
    check_eq("b2b_idle", bus.rvalid, 0);
    wait_drain();
    check_eq("b2b_hs", hs_cnt - hs0, 5);
    check_eq("b2b_fin", fin_cnt - fin0, 2);

    // Full queue drops the third push.
    bus.rready = 1'b0;
    hs0 = hs_cnt; fin0 = fin_cnt;
    push_rsp(4'd6, 2'd1, 128'h0000_0000_0000_0000_6666_0002_6666_0001);
    push_rsp(4'd7, 2'd0, 128'h0000_0000_0000_0000_0000_0000_7777_0001);
    push_rsp(4'd8, 2'd2, 128'h0000_0000_8888_0003_8888_0002_8888_0001);
    check_eq("full_after2", bus.rsp_full, 1);
    bus.rready = 1'b1;
    wait_drain();
    for (int i = 0; i < 4; i++) step();
    check_eq("full_hs", hs_cnt - hs0, 3);
    check_eq("full_fin", fin_cnt - fin0, 2);
    check_eq("full_clear", bus.rsp_full, 0);

    // Reset after two beats of a four-beat burst.
    hs0 = hs_cnt;
    push_rsp(4'd9, 2'd3, 128'h9999_0004_9999_0003_9999_0002_9999_0001);
    step();
    step();
    check_eq("rst_mid_hs", hs_cnt - hs0, 2);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_rvalid", bus.rvalid, 0);
    sb.delete();
    model_cnt = 0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_eq("post_rst_rvalid", bus.rvalid, 0);
    check_eq("post_rst_full", bus.rsp_full, 0);
    check_eq("post_rst_hs", hs_cnt - hs0, 2);
    hs0 = hs_cnt;
    push_rsp(4'hA, 2'd1, 128'h0000_0000_0000_0000_AAAA_0002_AAAA_0001);
    wait_drain();
    check_eq("recover_hs", hs_cnt - hs0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
